// File: rtl/booth_cska_mul_add.sv
// booth_cska_mul_add: registered signed multiply-add (C + A*B + cin) built from a
// radix-8 Booth multiplier and carry-skip adders; one FIR tap.

module booth_cska_mul_add_cska #(
    parameter int W = 32,
    parameter int B = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);
    if (W % B != 0) begin : g_bad_block
        $error("CSKA width must be a multiple of the block size");
    end
    logic c, r, p;
    always_comb begin
        c = cin;
        r = 1'b0;
        p = 1'b0;
        s = '0;
        for (int k = 0; k < W / B; k++) begin
            p = &(a[k*B +: B] ^ b[k*B +: B]);
            r = c;
            for (int j = 0; j < B; j++) begin
                s[k*B+j] = a[k*B+j] ^ b[k*B+j] ^ r;
                r = (a[k*B+j] & b[k*B+j]) | ((a[k*B+j] ^ b[k*B+j]) & r);
            end
            c = p ? c : r;
        end
        cout = c;
    end
endmodule

module booth_cska_mul_add #(
    parameter int N          = 16,
    parameter int BLOCK_SIZE = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    input  logic [2*N-1:0] addend,
    input  logic           cin,
    output logic           out_valid,
    output logic [2*N-1:0] product,
    output logic [2*N-1:0] sum,
    output logic           cout
);
    localparam int W  = 2 * N;
    localparam int NG = (N + 3) / 3;
    localparam int EW = 3 * NG + 1;

    if (W % BLOCK_SIZE != 0) begin : g_bad_block
        $error("2N must be a multiple of BLOCK_SIZE");
    end

    logic [W-1:0]  ax, a2, a3, a4, inj, prod_c, sum_c;
    logic [EW-1:0] ext;
    logic [NG-1:0] negv;
    logic          cout_c;

    assign ax  = {{N{multiplicand[N-1]}}, multiplicand};
    assign a2  = ax << 1;
    assign a4  = ax << 2;
    assign ext = {{(EW-N-1){multiplier[N-1]}}, multiplier, 1'b0};

    booth_cska_mul_add_cska #(.W(W), .B(BLOCK_SIZE)) u_a3 (
        .a(ax), .b(a2), .cin(1'b0), .s(a3), .cout()
    );

    // Negative digits use ~sel; their +1 lands at bit 3i, gathered into one word.
    always_comb begin
        inj = '0;
        for (int i = 0; i < NG; i++) inj[3*i] = negv[i];
    end

    for (genvar i = 0; i < NG; i++) begin : g_pp
        logic [3:0]   g;
        logic [2:0]   v, mag;
        logic [W-1:0] sel, pp, prev, acc;
        assign g       = ext[3*i +: 4];
        assign v       = {g[2], 1'b0} + {2'b0, g[1]} + {2'b0, g[0]};
        assign mag     = g[3] ? 3'd4 - v : v;
        assign negv[i] = g[3] & ~&g[2:0];
        assign sel     = mag == 3'd1 ? ax : mag == 3'd2 ? a2 : mag == 3'd3 ? a3 :
                         mag == 3'd4 ? a4 : '0;
        assign pp      = (negv[i] ? ~sel : sel) << (3 * i);
        if (i == 0) begin : g_first
            assign prev = inj;
        end else begin : g_next
            assign prev = g_pp[i-1].acc;
        end
        booth_cska_mul_add_cska #(.W(W), .B(BLOCK_SIZE)) u_add (
            .a(prev), .b(pp), .cin(1'b0), .s(acc), .cout()
        );
    end

    assign prod_c = g_pp[NG-1].acc;

    booth_cska_mul_add_cska #(.W(W), .B(BLOCK_SIZE)) u_sum (
        .a(addend), .b(prod_c), .cin(cin), .s(sum_c), .cout(cout_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            product   <= '0;
            sum       <= '0;
            cout      <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                product <= prod_c;
                sum     <= sum_c;
                cout    <= cout_c;
            end
        end
    end
endmodule

// File: tb/tb_booth_cska_mul_add.sv
// tb_booth_cska_mul_add: directed vector table, reset/hold sequences, an 8-tap
// transposed FIR impulse check and random vectors against a behavioural model.

module tb_booth_cska_mul_add;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic [31:0] c = '0;
    logic        ci = 1'b0;
    logic        out_valid, cout;
    logic [31:0] product, sum;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    booth_cska_mul_add #(.N(16), .BLOCK_SIZE(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .multiplicand(a), .multiplier(b), .addend(c), .cin(ci),
        .out_valid(out_valid), .product(product), .sum(sum), .cout(cout)
    );

    // Transposed-form FIR: every tap sees x, tap k adds the registered sum of tap k+1.
    logic [15:0] fx = '0;
    logic [31:0] fs [9];
    logic [31:0] fp [8];
    logic [7:0]  fco, fov;
    assign fs[8] = '0;
    for (genvar k = 0; k < 8; k++) begin : g_fir
        booth_cska_mul_add #(.N(16), .BLOCK_SIZE(4)) u_tap (
            .clk(clk), .rst(rst), .in_valid(1'b1),
            .multiplicand(fx), .multiplier(16'(k < 4 ? k + 1 : 7 - k)),
            .addend(fs[k+1]), .cin(1'b0),
            .out_valid(fov[k]), .product(fp[k]), .sum(fs[k]), .cout(fco[k])
        );
    end

    typedef struct {
        logic [15:0] a, b;
        logic [31:0] c;
        logic        ci;
        logic [31:0] p, s;
        logic        co;
    } vec_t;
    vec_t tv [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [15:0] va, vb, input logic [31:0] vc, input logic vci);
        @(negedge clk);
        a = va; b = vb; c = vc; ci = vci; in_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] keep_p, keep_s, pm, sm;
        logic        keep_c, com;
        tv[0]  = '{16'd3,     16'd4,     32'd10,        1'b0, 32'h0000000C, 32'h00000016, 1'b0};
        tv[1]  = '{16'hFFF9,  16'd5,     32'd0,         1'b0, 32'hFFFFFFDD, 32'hFFFFFFDD, 1'b0};
        tv[2]  = '{16'h8000,  16'h8000,  32'd0,         1'b0, 32'h40000000, 32'h40000000, 1'b0};
        tv[3]  = '{16'h7FFF,  16'h8000,  32'd0,         1'b0, 32'hC0008000, 32'hC0008000, 1'b0};
        tv[4]  = '{16'd1,     16'd1,     32'hFFFFFFFF,  1'b0, 32'h00000001, 32'h00000000, 1'b1};
        tv[5]  = '{16'd0,     16'd0,     32'hFFFFFFFF,  1'b1, 32'h00000000, 32'h00000000, 1'b1};
        tv[6]  = '{16'hFFFF,  16'hFFFF,  32'd5,         1'b1, 32'h00000001, 32'h00000007, 1'b0};
        tv[7]  = '{16'd100,   16'hFFFD,  32'h00000200,  1'b0, 32'hFFFFFED4, 32'h000000D4, 1'b1};
        tv[8]  = '{16'd1234,  16'd5678,  32'd0,         1'b0, 32'h006AE9BC, 32'h006AE9BC, 1'b0};
        tv[9]  = '{16'h8000,  16'h7FFF,  32'd0,         1'b0, 32'hC0008000, 32'hC0008000, 1'b0};
        tv[10] = '{16'h7FFF,  16'h7FFF,  32'h80000000,  1'b1, 32'h3FFF0001, 32'hBFFF0002, 1'b0};

        #1;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset product", product, 32'd0);
        chk("reset sum", sum, 32'd0);
        chk("reset cout", 32'(cout), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            drive(tv[i].a, tv[i].b, tv[i].c, tv[i].ci);
            chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d product", i), product, tv[i].p);
            chk($sformatf("vec%0d sum", i), sum, tv[i].s);
            chk($sformatf("vec%0d cout", i), 32'(cout), 32'(tv[i].co));
        end

        // Hold: in_valid low with changed operands leaves results untouched.
        drive(16'd1, 16'd1, 32'hFFFFFFFF, 1'b0);
        keep_p = product; keep_s = sum; keep_c = cout;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid = 1'b0; a = 16'h1234; b = 16'h0F0F; c = 32'h55AA55AA; ci = 1'b1;
            @(posedge clk);
            #1;
            chk("hold out_valid", 32'(out_valid), 32'd0);
            chk("hold product", product, 32'h00000001);
            chk("hold sum", sum, keep_s);
            chk("hold cout", 32'(cout), 32'(keep_c));
        end

        // Asynchronous reset in the middle of a valid stream.
        drive(16'd3, 16'd4, 32'd10, 1'b0);
        @(negedge clk);
        a = 16'd7; b = 16'd9; in_valid = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("async rst product", product, 32'd0);
        chk("async rst sum", sum, 32'd0);
        chk("async rst out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("post rst out_valid", 32'(out_valid), 32'd0);
        chk("post rst product", product, 32'd0);
        drive(16'd7, 16'd9, 32'd1, 1'b1);
        chk("first valid out_valid", 32'(out_valid), 32'd1);
        chk("first valid sum", sum, 32'd65);
        @(negedge clk) in_valid = 1'b0;

        // FIR impulse response must replay the coefficients 1,2,3,4,3,2,1,0.
        @(negedge clk) fx = 16'd1;
        @(posedge clk);
        #1;
        chk("fir y0", fs[0], 32'd1);
        @(negedge clk) fx = 16'd0;
        for (int j = 1; j < 8; j++) begin
            @(posedge clk);
            #1;
            chk($sformatf("fir y%0d", j), fs[0], 32'(j < 4 ? j + 1 : 7 - j));
        end

        for (int i = 0; i < 10000; i++) begin
            logic [15:0] ra, rb;
            logic [31:0] rc;
            logic        rci;
            ra = 16'($urandom); rb = 16'($urandom); rc = $urandom; rci = 1'($urandom);
            pm = $signed({{16{ra[15]}}, ra}) * $signed({{16{rb[15]}}, rb});
            {com, sm} = {1'b0, rc} + {1'b0, pm} + {32'd0, rci};
            drive(ra, rb, rc, rci);
            chk("rand product", product, pm);
            chk("rand sum", sum, sm);
            chk("rand cout", 32'(cout), 32'(com));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
